// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode constants, opcode classes and sequencer states
// for the two-register-bus CPU control path.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ALU3_FIRST = 5'b00011;
    localparam logic [4:0] OP_AND        = 5'b00101;
    localparam logic [4:0] OP_ALU3_LAST  = 5'b01100;
    localparam logic [4:0] OP_MUL        = 5'b01110;
    localparam logic [4:0] OP_DIV        = 5'b01111;
    localparam logic [4:0] OP_NEG        = 5'b10000;
    localparam logic [4:0] OP_NOT        = 5'b10001;

    typedef enum logic [1:0] {
        CLS_ILLEGAL,
        CLS_ALU3,
        CLS_MULDIV,
        CLS_UNARY
    } op_class_t;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, DONE
    } state_t;

    function automatic op_class_t classify(input logic [4:0] op);
        if (op >= OP_ALU3_FIRST && op <= OP_ALU3_LAST)
            return CLS_ALU3;
        if (op == OP_MUL || op == OP_DIV)
            return CLS_MULDIV;
        if (op == OP_NEG || op == OP_NOT)
            return CLS_UNARY;
        return CLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Sequencer-to-datapath bundle: start/memory handshake, IR in,
// and every datapath strobe and select out.
interface alu_op_sequencer_if;
    logic        start;
    logic        mem_ready;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, PCin;
    logic        Zlowin, Zhighin, Zlowout, Zhighout;
    logic        Read, MDRin, MDRout, IRin, Yin;
    logic        LOin, HIin, Rin, Rout;
    logic [3:0]  reg_sel;
    logic [4:0]  operation;
    logic        busy, done, illegal;

    modport master (
        input  start, mem_ready, IR,
        output PCout, MARin, IncPC, PCin,
        output Zlowin, Zhighin, Zlowout, Zhighout,
        output Read, MDRin, MDRout, IRin, Yin,
        output LOin, HIin, Rin, Rout,
        output reg_sel, operation, busy, done, illegal
    );

    modport slave (
        output start, mem_ready, IR,
        input  PCout, MARin, IncPC, PCin,
        input  Zlowin, Zhighin, Zlowout, Zhighout,
        input  Read, MDRin, MDRout, IRin, Yin,
        input  LOin, HIin, Rin, Rout,
        input  reg_sel, operation, busy, done, illegal
    );
endinterface

// File: rtl/alu_op_sequencer_ir_decode.sv
// Combinational instruction field split and opcode classification.
module ir_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    output op_class_t   o_cls,
    output logic [4:0]  o_opcode,
    output logic [3:0]  o_ra,
    output logic [3:0]  o_rb,
    output logic [3:0]  o_rc
);
    logic w_unused_ir;

    assign o_opcode    = i_ir[31:27];
    assign o_ra        = i_ir[26:23];
    assign o_rb        = i_ir[22:19];
    assign o_rc        = i_ir[18:15];
    assign o_cls       = classify(i_ir[31:27]);
    assign w_unused_ir = ^i_ir[14:0];
endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle T0..T6 control sequencer driving the datapath strobes.
// Outputs are Moore-decoded from the state register and IR.
module alu_op_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic Clock,
    input  logic clear,
    alu_op_sequencer_if.master bus
);
    state_t     r_state;
    state_t     w_next;
    op_class_t  w_cls;
    logic [4:0] w_op;
    logic [3:0] w_ra, w_rb, w_rc;

    ir_decode u_dec (
        .i_ir     (bus.IR),
        .o_cls    (w_cls),
        .o_opcode (w_op),
        .o_ra     (w_ra),
        .o_rb     (w_rb),
        .o_rc     (w_rc)
    );

    // State register; clear aborts instantly so no writeback escapes.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state: memory wait loop in T1/T1W, class-dependent path after T3.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (bus.start) w_next = T0;
            T0:   w_next = T1;
            T1, T1W: w_next = bus.mem_ready ? T2 : T1W;
            T2:   w_next = T3;
            T3: begin
                unique case (w_cls)
                    CLS_ILLEGAL: w_next = IDLE;
                    CLS_UNARY:   w_next = T5;
                    default:     w_next = T4;
                endcase
            end
            T4:   w_next = T5;
            T5:   w_next = (w_cls == CLS_MULDIV) ? T6 : DONE;
            T6:   w_next = DONE;
            DONE: w_next = bus.start ? T0 : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode; every strobe defaults low.
    always_comb begin
        bus.PCout = 1'b0;  bus.MARin = 1'b0;
        bus.IncPC = 1'b0;  bus.PCin = 1'b0;
        bus.Zlowin = 1'b0; bus.Zhighin = 1'b0;
        bus.Zlowout = 1'b0; bus.Zhighout = 1'b0;
        bus.Read = 1'b0;   bus.MDRin = 1'b0;
        bus.MDRout = 1'b0; bus.IRin = 1'b0;
        bus.Yin = 1'b0;    bus.LOin = 1'b0;
        bus.HIin = 1'b0;   bus.Rin = 1'b0;
        bus.Rout = 1'b0;   bus.reg_sel = 4'd0;
        bus.operation = 5'd0;
        bus.busy = (r_state != IDLE);
        bus.done = 1'b0;   bus.illegal = 1'b0;
        unique case (r_state)
            T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1;
                bus.IncPC = 1'b1; bus.Zlowin = 1'b1;
            end
            T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1;
                bus.Read = 1'b1;    bus.MDRin = 1'b1;
            end
            T1W: begin
                bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            T3: begin
                bus.operation = w_op;
                unique case (w_cls)
                    CLS_ALU3: begin
                        bus.Rout = 1'b1; bus.Yin = 1'b1;
                        bus.reg_sel = w_rb;
                    end
                    CLS_MULDIV: begin
                        bus.Rout = 1'b1; bus.Yin = 1'b1;
                        bus.reg_sel = w_ra;
                    end
                    CLS_UNARY: begin
                        bus.Rout = 1'b1; bus.Zlowin = 1'b1;
                        bus.reg_sel = w_rb;
                    end
                    default: bus.illegal = 1'b1;
                endcase
            end
            T4: begin
                bus.operation = w_op;
                bus.Rout = 1'b1; bus.Zlowin = 1'b1;
                if (w_cls == CLS_MULDIV) begin
                    bus.reg_sel = w_rb;
                    bus.Zhighin = 1'b1;
                end else begin
                    bus.reg_sel = w_rc;
                end
            end
            T5: begin
                bus.Zlowout = 1'b1;
                if (w_cls == CLS_MULDIV) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.Rin = 1'b1;
                    bus.reg_sel = w_ra;
                end
            end
            T6: begin
                bus.Zhighout = 1'b1; bus.HIin = 1'b1;
            end
            DONE: bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench for alu_op_sequencer.
// Driver issues instructions; monitor checks each completed one.
module tb_alu_op_sequencer;

    logic Clock = 1'b0;
    logic clear;
    int checks = 0;
    int errors = 0;

    alu_op_sequencer_if bus();

    alu_op_sequencer dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int         cls;
        int         lat;
        int         waits;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {3'd0,
                bus.PCout, bus.MARin, bus.IncPC, bus.PCin,
                bus.Zlowin, bus.Zhighin, bus.Zlowout, bus.Zhighout,
                bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin,
                bus.LOin, bus.HIin, bus.Rin, bus.Rout,
                bus.busy, bus.done, bus.illegal,
                bus.reg_sel, bus.operation};
    endfunction

    // Reference: 0 illegal, 1 three-register ALU, 2 mul/div, 3 unary.
    function automatic exp_t model(logic [31:0] ir, int waits);
        exp_t e;
        int   op;
        op = int'(ir[31:27]);
        e.op = ir[31:27];
        e.ra = ir[26:23];
        e.rb = ir[22:19];
        e.rc = ir[18:15];
        e.waits = waits;
        if (op >= 3 && op <= 12) begin
            e.cls = 1; e.lat = 7;
        end else if (op == 14 || op == 15) begin
            e.cls = 2; e.lat = 8;
        end else if (op == 16 || op == 17) begin
            e.cls = 3; e.lat = 6;
        end else begin
            e.cls = 0; e.lat = 4;
        end
        e.lat += waits;
        return e;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        int k, op, x;
        r = $urandom();
        k = $urandom_range(0, 3);
        case (k)
            0: op = $urandom_range(3, 12);
            1: op = 14 + $urandom_range(0, 1);
            2: op = 16 + $urandom_range(0, 1);
            default: begin
                x = $urandom_range(0, 17);
                if (x < 3)       op = x;
                else if (x == 3) op = 13;
                else             op = x + 14;
            end
        endcase
        r[31:27] = 5'(op);
        return r;
    endfunction

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    endtask

    task automatic issue(logic [31:0] ir, int waits, bit hold);
        int n;
        sb.push_back(model(ir, waits));
        bus.start = 1'b1;
        bus.IR = ir;
        @(posedge Clock); @(negedge Clock);
        chk("t0_after_start", 32'(bus.PCout), 32'd1);
        bus.start = hold;
        bus.mem_ready = 1'($urandom);
        @(posedge Clock); @(negedge Clock);
        for (int k = 0; k <= waits; k++) begin
            bus.mem_ready = (k == waits);
            if (!hold) bus.start = 1'($urandom);
            @(posedge Clock); @(negedge Clock);
        end
        n = 0;
        while (!(bus.done || bus.illegal) && n < 20) begin
            bus.mem_ready = 1'($urandom);
            if (!hold) bus.start = 1'($urandom);
            @(posedge Clock); @(negedge Clock);
            n++;
        end
        if (n >= 20) begin
            chk("done_timeout", 32'(n), 32'd0);
            finish_now();
        end
        if (bus.illegal) begin
            bus.start = hold;
            @(posedge Clock); @(negedge Clock);
        end
    endtask

    task automatic idle(int n);
        bus.start = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    // Monitor: gathers per-instruction activity, checks at done/illegal.
    logic [3:0] reads[$];
    initial begin : monitor
        bit tracking;
        int c, rd_n, pcin_n, rin_n, lo_n, hi_n, zh_n;
        int lo_c, hi_c, busy_lo;
        logic [4:0] eval_op;
        logic [3:0] rin_reg;
        exp_t e;
        tracking = 0;
        c = 0; rd_n = 0; pcin_n = 0; rin_n = 0;
        lo_n = 0; hi_n = 0; zh_n = 0;
        lo_c = 0; hi_c = 0; busy_lo = 0;
        eval_op = '0; rin_reg = '0;
        forever begin
            @(negedge Clock);
            if (clear) begin
                tracking = 0;
            end else begin
                if (bus.PCout) begin
                    tracking = 1; c = 0; reads.delete();
                    rd_n = 0; pcin_n = 0; rin_n = 0;
                    lo_n = 0; hi_n = 0; zh_n = 0;
                    lo_c = 0; hi_c = 0; busy_lo = 0;
                    eval_op = '0; rin_reg = '0;
                end
                if (tracking) begin
                    c++;
                    if (!bus.busy) busy_lo++;
                    if (bus.Read && bus.MDRin) rd_n++;
                    if (bus.PCin) pcin_n++;
                    if (bus.Rout) reads.push_back(bus.reg_sel);
                    if (bus.Rout && bus.Zlowin) eval_op = bus.operation;
                    if (bus.Zhighin) zh_n++;
                    if (bus.Rin) begin
                        rin_n++; rin_reg = bus.reg_sel;
                    end
                    if (bus.LOin) begin lo_n++; lo_c = c; end
                    if (bus.HIin) begin hi_n++; hi_c = c; end
                    if (bus.done || bus.illegal) begin
                        tracking = 0;
                        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            chk("latency", 32'(c), 32'(e.lat));
                            chk("illegal_flag", 32'(bus.illegal),
                                32'(e.cls == 0));
                            chk("fetch_read_cycles", 32'(rd_n),
                                32'(e.waits + 1));
                            chk("pcin_once", 32'(pcin_n), 32'd1);
                            chk("busy_high", 32'(busy_lo), 32'd0);
                            case (e.cls)
                                1: begin
                                    chk("alu3_nreads", 32'(reads.size()), 32'd2);
                                    if (reads.size() == 2) begin
                                        chk("alu3_rb", 32'(reads[0]), 32'(e.rb));
                                        chk("alu3_rc", 32'(reads[1]), 32'(e.rc));
                                    end
                                    chk("alu3_op", 32'(eval_op), 32'(e.op));
                                    chk("alu3_rin", 32'(rin_n), 32'd1);
                                    chk("alu3_dst", 32'(rin_reg), 32'(e.ra));
                                    chk("alu3_hilo", 32'(lo_n + hi_n + zh_n), 32'd0);
                                end
                                2: begin
                                    chk("md_nreads", 32'(reads.size()), 32'd2);
                                    if (reads.size() == 2) begin
                                        chk("md_ra", 32'(reads[0]), 32'(e.ra));
                                        chk("md_rb", 32'(reads[1]), 32'(e.rb));
                                    end
                                    chk("md_op", 32'(eval_op), 32'(e.op));
                                    chk("md_zhigh", 32'(zh_n), 32'd1);
                                    chk("md_rin", 32'(rin_n), 32'd0);
                                    chk("md_lo", 32'(lo_n), 32'd1);
                                    chk("md_hi", 32'(hi_n), 32'd1);
                                    chk("md_hi_after_lo", 32'(hi_c), 32'(lo_c + 1));
                                end
                                3: begin
                                    chk("un_nreads", 32'(reads.size()), 32'd1);
                                    if (reads.size() == 1)
                                        chk("un_rb", 32'(reads[0]), 32'(e.rb));
                                    chk("un_op", 32'(eval_op), 32'(e.op));
                                    chk("un_rin", 32'(rin_n), 32'd1);
                                    chk("un_dst", 32'(rin_reg), 32'(e.ra));
                                    chk("un_hilo", 32'(lo_n + hi_n + zh_n), 32'd0);
                                end
                                default: begin
                                    chk("ill_nreads", 32'(reads.size()), 32'd0);
                                    chk("ill_wb", 32'(rin_n + lo_n + hi_n), 32'd0);
                                end
                            endcase
                        end
                    end
                end else if (bus.Rin || bus.LOin || bus.HIin) begin
                    chk("stray_writeback", 32'd1, 32'd0);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] ir;
        int n, seen;
        bit hold;
        clear = 1'b1;
        bus.start = 1'b0;
        bus.mem_ready = 1'b0;
        bus.IR = '0;
        @(negedge Clock);
        chk("reset_outputs", outs(), 32'd0);
        @(negedge Clock);
        clear = 1'b0;
        @(negedge Clock);
        chk("idle_outputs", outs(), 32'd0);

        issue(32'h2A2B8000, 0, 0);
        idle(2);
        issue(32'h79300000, 0, 0);
        idle(1);
        issue(32'h2A2B8000, 3, 0);
        idle(1);
        issue(32'hF8000000, 0, 0);
        idle(1);
        issue(32'h80B00000, 0, 1);
        issue(32'h8A380000, 0, 1);
        idle(2);

        repeat (60) begin
            ir = rand_ir();
            n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            hold = ($urandom_range(0, 3) == 0);
            issue(ir, n, hold);
            if (!hold) idle($urandom_range(0, 2));
        end
        idle(2);

        ir = 32'h2A2B8000;
        bus.IR = ir;
        bus.start = 1'b1;
        @(posedge Clock); @(negedge Clock);
        bus.start = 1'b0;
        bus.mem_ready = 1'b1;
        n = 0;
        while (!(bus.Rout && bus.Zlowin && !bus.Yin) && n < 20) begin
            @(posedge Clock); @(negedge Clock);
            n++;
        end
        chk("reach_t4", 32'(n < 20), 32'd1);
        #2 clear = 1'b1;
        #1 chk("clear_outputs", outs(), 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        #2 clear = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge Clock);
            if (bus.Rin || bus.LOin || bus.HIin || bus.busy) seen++;
        end
        chk("no_wb_after_clear", 32'(seen), 32'd0);

        issue(32'h2A2B8000, 1, 0);
        idle(3);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        finish_now();
    end

endmodule
